// File: rtl/inst_buffer.sv
// inst_buffer: DEPTH-entry in-order FIFO from fetch check to decode, emptied on any redirect.
// Optional zero-latency bypass of an empty buffer is enabled with `define INST_BUF_BYPASS_EN.
module inst_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              excp_flush,
  input  logic              ertn_flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_inst,
  input  logic              in_excp,
  input  logic [3:0]        in_excp_num,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst,
  output logic              out_excp,
  output logic [3:0]        out_excp_num,
  output logic [ADDR_W:0]   count
);

  localparam int ENTRY_W = 69;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] in_entry;
  logic [ADDR_W:0]    wr_ptr;
  logic [ADDR_W:0]    rd_ptr;
  logic               empty;
  logic               full;
  logic               kill;
  logic               push;
  logic               pop;
  logic               bypass;

  assign kill     = flush | excp_flush | ertn_flush;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign in_ready = !full && !kill;
  assign in_entry = {in_pc, in_inst, in_excp, in_excp_num};
  assign head     = mem[rd_ptr[ADDR_W-1:0]];

`ifdef INST_BUF_BYPASS_EN
  // An empty buffer hands the incoming entry straight to decode instead of storing it.
  assign bypass = empty && in_valid && out_ready && !kill;
`else
  assign bypass = 1'b0;
`endif

  assign push  = in_valid && in_ready && !bypass;
  assign pop   = !empty && !kill && out_ready;
  assign count = wr_ptr - rd_ptr;

  always_comb begin
    out_valid = !empty && !kill;
    {out_pc, out_inst, out_excp, out_excp_num} = head;
    if (bypass) begin
      out_valid = 1'b1;
      {out_pc, out_inst, out_excp, out_excp_num} = in_entry;
    end
  end

  // A redirect abandons every buffered entry together with this cycle's push and pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (kill) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= in_entry;
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: table-driven fill/full/drain run plus flush, exception,
// bypass-or-latency and mid-operation reset sequences.
module tb_inst_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush, excp_flush, ertn_flush;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic        in_excp;
  logic [3:0]  in_excp_num;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
  logic        out_excp;
  logic [3:0]  out_excp_num;
  logic [3:0]  count;

  int checks = 0;
  int failures = 0;

  inst_buffer #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .excp_flush(excp_flush),
    .ertn_flush(ertn_flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_excp(in_excp), .in_excp_num(in_excp_num),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_excp(out_excp), .out_excp_num(out_excp_num), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic        out_ready;
    logic [31:0] pc;
    logic        exp_out_valid;
    logic        exp_in_ready;
    logic [3:0]  exp_count;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[21];

  function automatic logic [31:0] pcf(int k);
    return 32'h1c000000 + 32'(4 * k);
  endfunction

  function automatic logic [31:0] inst_of(logic [31:0] pc);
    return pc ^ 32'h02800000;
  endfunction

  function automatic vec_t mk(logic iv, logic orr, logic [31:0] pc, logic ev, logic eir,
                              logic [3:0] ec, logic [31:0] epc);
    vec_t v;
    v.in_valid = iv; v.out_ready = orr; v.pc = pc;
    v.exp_out_valid = ev; v.exp_in_ready = eir; v.exp_count = ec; v.exp_pc = epc;
    return v;
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and let combinational outputs settle before checking.
  task automatic apply_stimulus(logic iv, logic orr, logic [31:0] pc, logic ex, logic [3:0] num,
                                logic fl, logic ef, logic er);
    in_valid = iv; out_ready = orr; in_pc = pc; in_inst = inst_of(pc);
    in_excp = ex; in_excp_num = num; flush = fl; excp_flush = ef; ertn_flush = er;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(string name, logic [31:0] pc, logic ex, logic [3:0] num);
    check_output({name, ".valid"}, 32'(out_valid), 32'd1);
    check_output({name, ".pc"}, out_pc, pc);
    check_output({name, ".inst"}, out_inst, inst_of(pc));
    check_output({name, ".excp"}, 32'(out_excp), 32'(ex));
    check_output({name, ".excp_num"}, 32'(out_excp_num), 32'(num));
  endtask

  initial begin
    vecs[0] = mk(1'b1, 1'b0, pcf(0), 1'b0, 1'b1, 4'd0, 32'h0);
    for (int k = 1; k < 8; k++)
      vecs[k] = mk(1'b1, 1'b0, pcf(k), 1'b1, 1'b1, 4'(k), pcf(0));
    vecs[8]  = mk(1'b1, 1'b0, pcf(8), 1'b1, 1'b0, 4'd8, pcf(0));
    vecs[9]  = mk(1'b1, 1'b1, pcf(8), 1'b1, 1'b0, 4'd8, pcf(0));
    vecs[10] = mk(1'b1, 1'b0, pcf(8), 1'b1, 1'b1, 4'd7, pcf(1));
    vecs[11] = mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 4'd8, pcf(1));
    for (int k = 0; k < 8; k++)
      vecs[12+k] = mk(1'b0, 1'b1, 32'h0, 1'b1, (k != 0), 4'(8 - k), pcf(1 + k));
    vecs[20] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'd0, 32'h0);

    reset_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    check_output("reset.out_valid", 32'(out_valid), 32'd0);
    check_output("reset.in_ready", 32'(in_ready), 32'd1);
    check_output("reset.count", 32'(count), 32'd0);

    for (int i = 0; i < 21; i++) begin
      apply_stimulus(vecs[i].in_valid, vecs[i].out_ready, vecs[i].pc, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      check_output($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].exp_out_valid));
      check_output($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
      check_output($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].exp_count));
      if (vecs[i].exp_out_valid) begin
        check_output($sformatf("vec%0d.out_pc", i), out_pc, vecs[i].exp_pc);
        check_output($sformatf("vec%0d.out_inst", i), out_inst, inst_of(vecs[i].exp_pc));
      end
      tick();
    end

    // Exception flush with three entries buffered and a push offered in the same cycle.
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, 1'b0, 32'h1c000080 + 32'(4 * k), 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    apply_stimulus(1'b1, 1'b0, 32'h0000dead, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    check_output("xflush.count_before", 32'(count), 32'd3);
    check_output("xflush.out_valid", 32'(out_valid), 32'd0);
    check_output("xflush.in_ready", 32'(in_ready), 32'd0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_output("xflush.count_after", 32'(count), 32'd0);
    check_output("xflush.out_valid_after", 32'(out_valid), 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'h1c0000c0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    check_output("bflush.count_before", 32'(count), 32'd1);
    check_output("bflush.out_valid", 32'(out_valid), 32'd0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_output("bflush.count_after", 32'(count), 32'd0);

    // Exception flag and code stay attached to the middle entry only.
    apply_stimulus(1'b1, 1'b0, 32'h1c000100, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 1'b0, 32'h1c000104, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 1'b0, 32'h1c000108, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_output("excp.count", 32'(count), 32'd3);
    check_head("excp.e0", 32'h1c000100, 1'b0, 4'h0);
    tick();
    check_head("excp.e1", 32'h1c000104, 1'b1, 4'h8);
    tick();
    check_head("excp.e2", 32'h1c000108, 1'b0, 4'h0);
    tick();
    check_output("excp.count_end", 32'(count), 32'd0);
    check_output("excp.valid_end", 32'(out_valid), 32'd0);

    // Empty buffer with a consumer already waiting.
    apply_stimulus(1'b1, 1'b1, 32'h1c000040, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
`ifdef INST_BUF_BYPASS_EN
    check_head("bypass.same", 32'h1c000040, 1'b0, 4'h0);
    check_output("bypass.count", 32'(count), 32'd0);
    tick();
    apply_stimulus(1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_output("bypass.count_next", 32'(count), 32'd0);
    check_output("bypass.valid_next", 32'(out_valid), 32'd0);
`else
    check_output("lat.valid_same", 32'(out_valid), 32'd0);
    check_output("lat.count_same", 32'(count), 32'd0);
    tick();
    apply_stimulus(1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_head("lat.next", 32'h1c000040, 1'b0, 4'h0);
    check_output("lat.count_next", 32'(count), 32'd1);
    tick();
    check_output("lat.count_end", 32'(count), 32'd0);
`endif

    // Asynchronous reset in the middle of operation drops buffered entries immediately.
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(1'b1, 1'b0, 32'h1c000200 + 32'(4 * k), 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_output("mreset.count_before", 32'(count), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check_output("mreset.count", 32'(count), 32'd0);
    check_output("mreset.out_valid", 32'(out_valid), 32'd0);
    check_output("mreset.in_ready", 32'(in_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();
    check_output("mreset.count_after", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
